// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the LSU data port.
// Data has fixed priority; a starvation counter forces fetch through periodically.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_wsel_byte_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_stall_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        resp_err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]              count, count_next, push_idx;
  logic [MAX_OUTSTANDING-1:0] ids, ids_next;   // ids[0] is the oldest; 1 = data
  logic [SW-1:0]              starve_cnt;
  logic                       full, sel_if, sel_lsu, push, pop;

  assign full = (count == CW'(MAX_OUTSTANDING));

  always_comb begin
    sel_if  = 1'b0;
    sel_lsu = 1'b0;
    if (!full) begin
      if (lsu_req_i && if_req_i) begin
        if (starve_cnt == SW'(STARVE_LIMIT)) sel_if = 1'b1;
        else                                 sel_lsu = 1'b1;
      end else begin
        sel_if  = if_req_i;
        sel_lsu = lsu_req_i;
      end
    end
  end

  assign bus_req_o   = sel_if | sel_lsu;
  assign if_gnt_o    = bus_gnt_i & sel_if;
  assign lsu_gnt_o   = bus_gnt_i & sel_lsu;
  assign lsu_stall_o = lsu_req_i & ~lsu_gnt_o;
  assign bus_addr_o  = sel_lsu ? lsu_addr_i      : if_addr_i;
  assign bus_we_o    = sel_lsu ? lsu_we_i        : 1'b0;
  assign bus_be_o    = sel_lsu ? lsu_wsel_byte_i : 4'b1111;
  assign bus_wdata_o = sel_lsu ? lsu_wdata_i     : 32'h0;

  assign push = if_gnt_o | lsu_gnt_o;
  // A response with nothing outstanding is flagged, never popped.
  assign pop  = bus_rvalid_i & (count != '0);

  assign if_rvalid_o  = pop & ~ids[0];
  assign lsu_rvalid_o = pop & ids[0];
  assign if_rdata_o   = bus_rdata_i;
  assign lsu_rdata_o  = bus_rdata_i;

  always_comb begin
    ids_next   = pop ? (ids >> 1) : ids;
    push_idx   = pop ? (count - CW'(1)) : count;
    count_next = count + CW'(push) - CW'(pop);
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (push && i == int'(push_idx)) ids_next[i] = lsu_gnt_o;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count      <= '0;
      ids        <= '0;
      starve_cnt <= '0;
      resp_err_o <= 1'b0;
    end else begin
      count <= count_next;
      ids   <= ids_next;
      if (bus_rvalid_i && count == '0) resp_err_o <= 1'b1;
      if (if_gnt_o || !if_req_i)
        starve_cnt <= '0;
      else if (lsu_gnt_o && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int MAXO = 2;
  localparam int LIM  = 4;

  logic        clk = 1'b0, rstn_i;
  logic        if_req_i, lsu_req_i, lsu_we_i, bus_gnt_i, bus_rvalid_i;
  logic [31:0] if_addr_i, lsu_addr_i, lsu_wdata_i, bus_rdata_i;
  logic [3:0]  lsu_wsel_byte_i;
  logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_stall_o, lsu_rvalid_o;
  logic        bus_req_o, bus_we_o, resp_err_o;
  logic [31:0] if_rdata_o, lsu_rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_wsel_byte_i(lsu_wsel_byte_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_stall_o(lsu_stall_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
    .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Reference model: in-flight originators in issue order (0 fetch, 1 data).
  int q[$];
  int starve = 0;
  bit err = 0;

  always @(negedge clk) begin
    bit full, wf, wd, eg_if, eg_d, pop;
    int head;
    if (!rstn_i) begin
      q.delete();
      starve = 0;
      err = 0;
    end
    full = (q.size() == MAXO);
    wf = 0; wd = 0;
    if (!full) begin
      if (if_req_i && lsu_req_i) begin
        if (starve == LIM) wf = 1; else wd = 1;
      end else begin
        wf = if_req_i; wd = lsu_req_i;
      end
    end
    eg_if = wf && bus_gnt_i;
    eg_d  = wd && bus_gnt_i;
    pop   = bus_rvalid_i && q.size() > 0;
    head  = pop ? q[0] : 0;
    chk("m_bus_req", bus_req_o, wf | wd);
    chk("m_if_gnt", if_gnt_o, eg_if);
    chk("m_lsu_gnt", lsu_gnt_o, eg_d);
    chk("m_lsu_stall", lsu_stall_o, lsu_req_i && !eg_d);
    chk("m_if_rvalid", if_rvalid_o, pop && head == 0);
    chk("m_lsu_rvalid", lsu_rvalid_o, pop && head == 1);
    chk("m_resp_err", resp_err_o, err);
    if (pop) begin
      chk("m_if_rdata", if_rdata_o, bus_rdata_i);
      chk("m_lsu_rdata", lsu_rdata_o, bus_rdata_i);
    end
    if (wd) begin
      chk("m_addr_d", bus_addr_o, lsu_addr_i);
      chk("m_we_d", bus_we_o, lsu_we_i);
      chk("m_be_d", bus_be_o, lsu_wsel_byte_i);
      chk("m_wdata_d", bus_wdata_o, lsu_wdata_i);
    end else if (wf) begin
      chk("m_addr_f", bus_addr_o, if_addr_i);
      chk("m_we_f", bus_we_o, 0);
      chk("m_be_f", bus_be_o, 4'hF);
      chk("m_wdata_f", bus_wdata_o, 0);
    end
    if (rstn_i) begin
      if (bus_rvalid_i && q.size() == 0) err = 1;
      if (pop) void'(q.pop_front());
      if (eg_if) q.push_back(0);
      if (eg_d) q.push_back(1);
      if (!if_req_i || eg_if) starve = 0;
      else if (eg_d && starve < LIM) starve++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_i = 0; lsu_req_i = 0; lsu_we_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
    if_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_wsel_byte_i = 0; bus_rdata_i = 0;
  endtask

  task automatic contend(input string ifpat, input string exp, input string name);
    string got;
    got = "";
    for (int i = 0; i < ifpat.len(); i++) begin
      if_req_i = (ifpat[i] == "1"); lsu_req_i = 1; bus_gnt_i = 1;
      if_addr_i = 32'h1000 + i * 4; lsu_addr_i = 32'h2000 + i * 4;
      bus_rvalid_i = (i > 0); bus_rdata_i = 32'hC0DE0000 + i;
      @(negedge clk);
      if (if_gnt_o) got = {got, "F"};
      else if (lsu_gnt_o) got = {got, "D"};
      else got = {got, "-"};
      tick();
    end
    idle(); bus_rvalid_i = 1; bus_rdata_i = 32'hC0DEFFFF;
    tick();
    idle();
    chks(name, got, exp);
  endtask

  initial begin
    idle();
    rstn_i = 0;
    @(negedge clk);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_rvalid", {if_rvalid_o, lsu_rvalid_o}, 0);
    tick(); tick();
    rstn_i = 1;
    tick();

    // Data-only load
    lsu_req_i = 1; lsu_addr_i = 32'h100; bus_gnt_i = 1;
    @(negedge clk);
    chk("load_gnt", lsu_gnt_o, 1);
    chk("load_addr", bus_addr_o, 32'h100);
    tick();
    idle(); bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("load_rvalid", lsu_rvalid_o, 1);
    chk("load_rdata", lsu_rdata_o, 32'hDEADBEEF);
    chk("load_if_rvalid", if_rvalid_o, 0);
    tick(); idle();

    // Store
    lsu_req_i = 1; lsu_we_i = 1; lsu_wsel_byte_i = 4'b0100;
    lsu_wdata_i = 32'h00AB0000; lsu_addr_i = 32'h300; bus_gnt_i = 1;
    @(negedge clk);
    chk("st_we", bus_we_o, 1);
    chk("st_be", bus_be_o, 4'b0100);
    chk("st_wdata", bus_wdata_o, 32'h00AB0000);
    tick();
    idle(); bus_rvalid_i = 1;
    @(negedge clk);
    chk("st_rvalid", lsu_rvalid_o, 1);
    tick(); idle();

    // Ordering: fetch then data, responses routed in issue order
    if_req_i = 1; if_addr_i = 32'h0; bus_gnt_i = 1;
    @(negedge clk);
    chk("ord_if_gnt", if_gnt_o, 1);
    chk("ord_be_f", bus_be_o, 4'hF);
    tick();
    if_req_i = 0; lsu_req_i = 1; lsu_addr_i = 32'h200;
    @(negedge clk);
    chk("ord_lsu_gnt", lsu_gnt_o, 1);
    tick();
    idle(); bus_rvalid_i = 1; bus_rdata_i = 32'hAAAA0001;
    @(negedge clk);
    chk("ord_a_route", {if_rvalid_o, lsu_rvalid_o}, 2'b10);
    chk("ord_a_data", if_rdata_o, 32'hAAAA0001);
    tick();
    bus_rdata_i = 32'hBBBB0002;
    @(negedge clk);
    chk("ord_b_route", {if_rvalid_o, lsu_rvalid_o}, 2'b01);
    chk("ord_b_data", lsu_rdata_o, 32'hBBBB0002);
    tick(); idle();

    // Full: bus stalls first, then two grants fill the window
    lsu_req_i = 1; lsu_addr_i = 32'h400; bus_gnt_i = 0;
    @(negedge clk);
    chk("busy_req", bus_req_o, 1);
    chk("busy_stall", lsu_stall_o, 1);
    tick();
    bus_gnt_i = 1; tick(); tick();
    @(negedge clk);
    chk("full_req", bus_req_o, 0);
    chk("full_stall", lsu_stall_o, 1);
    tick();
    bus_rvalid_i = 1;
    @(negedge clk);
    chk("full_pop_same", bus_req_o, 0);
    tick();
    @(negedge clk);
    chk("full_regnt", lsu_gnt_o, 1);
    chk("full_regnt_rv", lsu_rvalid_o, 1);
    tick();
    lsu_req_i = 0; tick();
    idle(); tick();

    // Contention: starvation counter forces fetch every fifth grant
    contend("1111111111", "DDDDFDDDDF", "starve_pattern");
    contend("111011111", "DDDDDDDDF", "starve_clear");

    // Reset with a transaction in flight, then a stray response
    lsu_req_i = 1; bus_gnt_i = 1;
    tick();
    idle();
    rstn_i = 0;
    @(negedge clk);
    chk("mid_rst_err", resp_err_o, 0);
    tick();
    rstn_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h5;
    @(negedge clk);
    chk("spur_no_pulse", {if_rvalid_o, lsu_rvalid_o}, 0);
    tick();
    idle();
    @(negedge clk);
    chk("spur_err", resp_err_o, 1);
    tick(); tick();
    @(negedge clk);
    chk("spur_sticky", resp_err_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
